arb_request_queue: RTL
======================

Name: arb_request_queue

Overview:
- Requester-side client for the shared round-robin arbiter: one instance per unit that contends for a shared resource.
- Buffers outgoing transactions in a small FIFO and drives that unit's request bit into the arbiter.
- Consumes the unit's bit of the arbiter's registered one-hot grant.
- Issues the head transaction onto the shared resource in the cycle its grant arrives.

Parameters:
- DATA_WIDTH, 32, width of one queued transaction.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- ADDR_WIDTH, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- enqueue_en  input  1  push enqueue_data this cycle.
- enqueue_data  input  DATA_WIDTH  transaction to push.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= DEPTH-1.
- request  output  1  to the arbiter's request bit for this unit.
- grant  input  1  this unit's bit of the arbiter's grant_oh.
- issue_valid  output  1  head transaction is issued this cycle.
- issue_data  output  DATA_WIDTH  head entry; valid only while issue_valid is high.
- overflow  output  1  sticky: an enqueue was attempted while full.
- spurious_grant  output  1  sticky: grant arrived outside the REQ state.

Behaviour:
- Arbiter timing contract: grant in cycle t reflects request in cycle t-1. The arbiter updates its grant register every cycle.
- Storage: DEPTH x DATA_WIDTH register array, plus head_ptr, tail_ptr (ADDR_WIDTH, wrap modulo DEPTH) and count (ADDR_WIDTH+1 bits).
- Reset, synchronous: head_ptr=0, tail_ptr=0, count=0, state=IDLE, overflow=0, spurious_grant=0.
  - Resulting outputs: request=0, issue_valid=0, full=0, almost_full=0.
  - Array contents are don't-care.
  - Reset mid-request discards all queued entries. Any grant arriving in the cycle after reset sets spurious_grant and is otherwise ignored.
- State machine has two states, IDLE and REQ.
  - IDLE -> REQ when count != 0 or enqueue_en (accepted). Request is therefore visible in the cycle after the first push.
  - REQ with grant: pop. Next state is REQ if count_after_pop + accepted_push != 0, else IDLE.
  - REQ without grant: stay in REQ.
- request = (state == REQ) && !grant.
  - Dropping request combinationally in the grant cycle stops the arbiter re-granting in the following cycle.
  - Consequence: at most one issue every 2 cycles per unit.
- issue_valid = (state == REQ) && grant. issue_data = mem[head_ptr]. Both are combinational from registered state and the registered grant.
- Pop on issue_valid: head_ptr increments and count decrements at the clock edge.
- Push on enqueue_en && !full: mem[tail_ptr] <= enqueue_data, tail_ptr increments, count increments.
- Enqueue while full: data dropped, state unchanged, overflow <= 1.
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, a push in the same cycle as a pop is still rejected, because full is evaluated before the pop.
- Grant while IDLE: no pop, issue_valid=0, spurious_grant <= 1.
- Sticky flags clear only on reset.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Ordering: strictly FIFO. Latency from enqueue into an empty queue to issue is 2 cycles, assuming an uncontended arbiter.

Decomposition:
- Shared package: arbiter-client state encoding (IDLE=1'b0, REQ=1'b1) and a default-depth constant, reused by future arbiter clients.
- One natural sub-module, sync_fifo_ctr: pointer/count/full/almost_full bookkeeping plus storage, with push/pop inputs.
- arb_request_queue wraps sync_fifo_ctr with the request/grant FSM and the error flags.

Test Plan:
- Single entry: after reset, enqueue 0xA5A5A5A5 at cycle 0 -> request=1 at cycle 1. Bench arbiter asserts grant at cycle 2 -> issue_valid=1 and issue_data=0xA5A5A5A5 at cycle 2, request=0 at cycle 2, state IDLE at cycle 3.
- Fill and drain: push 1,2,3,4 back-to-back -> full=1 after the 4th push. A 5th push of 5 sets overflow=1. Grants every cycle while request is high yield issues 1,2,3,4 on alternating cycles; 5 is never issued.
- Wrap: push 4 entries, drain 2, push 2 more (tail wraps to 0-1), drain 4 -> issue order is preserved across the pointer wrap and count returns to 0.
- Simultaneous push/pop: with count=2, push 0x77 in the grant cycle -> count stays 2, request is re-asserted the next cycle, and 0x77 is issued last.
- Contention: two instances behind a 2-entry arbiter, both holding 3 entries -> issues alternate unit0/unit1, no unit is granted twice in a row while the other requests, and no spurious_grant is raised.
- Error and reset: inject grant while IDLE -> spurious_grant=1, no pop. Assert reset for 1 cycle with 3 entries queued -> count=0, request=0, both flags clear.

Source files
------------

// File: rtl/arb_request_queue_pkg.sv
// Shared definitions for arbiter clients.
//   arb_client_state_e            : request/grant FSM encoding (IDLE=0, REQ=1)
//   ARB_CLIENT_DEFAULT_DEPTH      : default FIFO depth for a client queue
//   ARB_CLIENT_DEFAULT_DATA_WIDTH : default width of one queued transaction
package arb_request_queue_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_REQ  = 1'b1
  } arb_client_state_e;

  localparam int unsigned ARB_CLIENT_DEFAULT_DEPTH      = 4;
  localparam int unsigned ARB_CLIENT_DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/arb_request_queue_if.sv
// Bus bundle between one requesting unit, its request queue and the arbiter.
//   enqueue_en/enqueue_data : push side from the unit
//   full/almost_full        : occupancy back to the unit
//   request/grant           : this unit's bit towards/from the arbiter
//   issue_valid/issue_data  : head transaction onto the shared resource
//   overflow/spurious_grant : sticky error flags
// Modport slave is the queue itself; master is the surrounding environment.
interface arb_request_queue_if
  import arb_request_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ARB_CLIENT_DEFAULT_DATA_WIDTH
);

  logic                  enqueue_en;
  logic [DATA_WIDTH-1:0] enqueue_data;
  logic                  full;
  logic                  almost_full;
  logic                  request;
  logic                  grant;
  logic                  issue_valid;
  logic [DATA_WIDTH-1:0] issue_data;
  logic                  overflow;
  logic                  spurious_grant;

  modport slave (
    input  enqueue_en, enqueue_data, grant,
    output full, almost_full, request, issue_valid, issue_data,
           overflow, spurious_grant
  );

  modport master (
    output enqueue_en, enqueue_data, grant,
    input  full, almost_full, request, issue_valid, issue_data,
           overflow, spurious_grant
  );

endinterface

// File: rtl/arb_request_queue_sync_fifo_ctr.sv
// Synchronous FIFO: storage plus head/tail pointer and occupancy bookkeeping.
//   clk, reset   : clock and synchronous active-high reset
//   push         : push request; accepted only when not full (push_ok)
//   push_data    : data written at the tail on an accepted push
//   pop          : remove the head entry (ignored when empty)
//   head_data    : entry at the head pointer
//   count_next   : occupancy after this cycle's push/pop
//   full         : count == DEPTH
//   almost_full  : count >= DEPTH-1
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo_ctr
  import arb_request_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ARB_CLIENT_DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = ARB_CLIENT_DEFAULT_DEPTH,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  push_ok,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_WIDTH:0]   count_next,
  output logic                  full,
  output logic                  almost_full
);

  localparam logic [ADDR_WIDTH:0]   COUNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_AF    = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO    = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE     = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  pop_ok;

  // Occupancy flags and accept qualifiers; full is judged before any pop,
  // so a push into a full queue is rejected even when a pop happens too.
  always_comb begin
    full        = (count_q == COUNT_DEPTH);
    almost_full = (count_q >= COUNT_AF);
    push_ok     = push & ~full;
    pop_ok      = pop & (count_q != COUNT_ZERO);
    head_data   = mem_q[head_q];
  end

  // Pointer and count next-state.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_ok) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end
    if (push_ok) begin
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
    count_next = count_d;
  end

  // Storage next-state: write the tail slot on an accepted push.
  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[tail_q] = push_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= PTR_ZERO;
      tail_q  <= PTR_ZERO;
      count_q <= COUNT_ZERO;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/arb_request_queue.sv
// Requester-side client of the shared round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   bus        : arb_request_queue_if.slave (enqueue, occupancy, request/grant,
//                issue and sticky error flags)
// Queued transactions raise request; the arbiter answers one cycle later
// with grant, and the head entry is issued in that grant cycle. Request is
// dropped combinationally during the grant cycle so the arbiter cannot
// re-grant this unit back-to-back, giving at most one issue per two cycles.
module arb_request_queue
  import arb_request_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ARB_CLIENT_DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = ARB_CLIENT_DEFAULT_DEPTH,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input logic                clk,
  input logic                reset,
  arb_request_queue_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] COUNT_ZERO = {(ADDR_WIDTH+1){1'b0}};

  arb_client_state_e     state_q, state_d;
  logic                  overflow_q, overflow_d;
  logic                  spurious_q, spurious_d;
  logic                  request;
  logic                  issue_valid;
  logic                  push_ok;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count_next;
  logic [DATA_WIDTH-1:0] head_data;

  sync_fifo_ctr #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (bus.enqueue_en),
    .push_data   (bus.enqueue_data),
    .pop         (issue_valid),
    .push_ok     (push_ok),
    .head_data   (head_data),
    .count_next  (count_next),
    .full        (full),
    .almost_full (almost_full)
  );

  // Request/issue decode from the registered state and registered grant.
  always_comb begin
    request     = 1'b0;
    issue_valid = 1'b0;
    if (state_q == ARB_REQ) begin
      request     = ~bus.grant;
      issue_valid = bus.grant;
    end else begin
      request     = 1'b0;
      issue_valid = 1'b0;
    end
  end

  // FSM next state. In IDLE no pop can happen, so count_next != 0 is exactly
  // "already holding entries or accepting a push now".
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (count_next != COUNT_ZERO) begin
          state_d = ARB_REQ;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        if (bus.grant && (count_next == COUNT_ZERO)) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_REQ;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Sticky error flags, cleared only by reset.
  always_comb begin
    overflow_d = overflow_q | (bus.enqueue_en & full);
    spurious_d = spurious_q | (bus.grant & (state_q == ARB_IDLE));
  end

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      overflow_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      spurious_q <= spurious_d;
    end
  end

  assign bus.request        = request;
  assign bus.issue_valid    = issue_valid;
  assign bus.issue_data     = head_data;
  assign bus.full           = full;
  assign bus.almost_full    = almost_full;
  assign bus.overflow       = overflow_q;
  assign bus.spurious_grant = spurious_q;

  // push_ok is consumed inside the FIFO; kept here for readability of the
  // accept condition when probing the design.
  logic unused_push_ok;
  assign unused_push_ok = push_ok;

endmodule
